mult_share_arbiter: RTL
=======================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one iterative signed shift-add multiplier among N_REQ requesters.
//  - Round-robin arbitration; valid/ready handshake per requester.
//  - Sequences the engine: sign extraction, W add/shift steps, sign fix.
//  - Returns a tagged 2W-bit product; sits between client ports and the shared datapath.
// PARAMETERS
//  N_REQ  4   number of requesters (>=2)
//  W      32  operand width; product width is 2*W
//  IDW    2   tag width, clog2(N_REQ)
// PORTS
//  clk           in   1          rising-edge clock
//  reset         in   1          synchronous, active-high
//  req_valid     in   N_REQ      request i has operands on req_a/req_b slice i
//  req_ready     out  N_REQ      one-hot grant; handshake when valid&ready
//  req_a         in   N_REQ*W    signed multiplicand; slice i = [i*W +: W]
//  req_b         in   N_REQ*W    signed multiplier; slice i = [i*W +: W]
//  resp_valid    out  1          product available
//  resp_ready    in   1          consumer accepts product
//  resp_id       out  IDW        index of the requester that owns resp_product
//  resp_product  out  2*W        signed a*b, two's complement
//  busy          out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_id=0,
//   resp_product=0, busy=0, count=0, accumulator=0. Reset has priority over all else.
//  FSM: IDLE -> RUN -> FIX -> DONE -> IDLE.
//  IDLE:
//   - Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... (mod N_REQ).
//   - req_ready = one-hot(winner), combinational; all zero if no request or not IDLE.
//   - On handshake, capture:
//     mag_a = |a|, mag_b = |b| as W-bit unsigned (-2^(W-1) -> 2^(W-1));
//     neg = a[W-1]^b[W-1]; id = winner; acc = 0; count = 0. Go to RUN.
//  RUN, W cycles, count = 0..W-1:
//   - If mag_a[count]: acc += {W'b0, mag_b} << count (2W-bit, no overflow).
//   - Leave for FIX after count == W-1. No early termination: fixed latency.
//  FIX, 1 cycle: resp_product <= neg ? -acc : acc.
//   Zero result gives 0 even if neg. Set resp_valid, resp_id = id. Go to DONE.
//  DONE:
//   - Hold resp_valid, resp_id, resp_product stable until resp_ready.
//   - On resp_valid & resp_ready: resp_valid <= 0, rr_ptr <= (id+1) mod N_REQ, go to IDLE.
//   - resp_product keeps its last value after the handshake.
//  Latency: handshake in cycle T -> resp_valid first high in cycle T+W+2.
//   Min spacing between grants is W+3 cycles (resp_ready held high).
//  Requesters withdrawing req_valid before grant: legal; not granted.
//  Operands are sampled only in the handshake cycle; later changes are ignored.
//  No new grant while busy, even with resp_ready high in DONE.
//   IDLE is re-entered first.
//  Reset in any state aborts the in-flight op. No response is produced.
// TESTING
//  1 Req0 a=3, b=-5, resp_ready=1 -> req_ready=0001 at T; resp_valid at T+34,
//    id=0, product=0xFFFFFFFFFFFFFFF1.
//  2 All four valid from reset, resp_ready=1 -> grant order 0,1,2,3,0.
//    Each product correct; grants spaced 35 cycles.
//  3 a=b=0x80000000 -> product 0x4000000000000000.
//    a=-1, b=-1 -> 1. a=0, b=-7 -> 0.
//  4 resp_ready=0 for 10 cycles in DONE -> resp_valid, id, product stable.
//    No req_ready asserted. Release -> IDLE next cycle.
//  5 Req1 and req3 valid, rr_ptr=2 -> req3 granted first, then req1.
//  6 Reset asserted mid-RUN at count=10 -> next cycle all outputs at reset values.
//    No resp_valid. Fresh request then completes normally.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin arbiter sharing one iterative signed shift-add multiplier
// Grants one requester at a time, runs W add/shift steps on the magnitudes, then applies the sign.
module mult_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 32,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [2*W-1:0]       resp_product,
    output logic                 busy
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   id;
    logic [W-1:0]     mag_a;
    logic [W-1:0]     mag_b;
    logic             neg;
    logic [2*W-1:0]   acc;
    logic [CW-1:0]    count;

    logic             found;
    logic [IDW-1:0]   winner;
    logic [IDW:0]     cand;
    logic             grant;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;

    // Rotating priority search starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
    end

    // No grant while reset is held, so nothing can handshake into a clearing engine.
    assign grant     = !reset && (state == IDLE) && found;
    assign req_ready = grant ? (N_REQ'(1) << winner) : '0;
    assign sel_a     = req_a[winner*W +: W];
    assign sel_b     = req_b[winner*W +: W];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            id           <= '0;
            mag_a        <= '0;
            mag_b        <= '0;
            neg          <= 1'b0;
            acc          <= '0;
            count        <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        mag_a <= sel_a[W-1] ? -sel_a : sel_a;
                        mag_b <= sel_b[W-1] ? -sel_b : sel_b;
                        neg   <= sel_a[W-1] ^ sel_b[W-1];
                        id    <= winner;
                        acc   <= '0;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (mag_a[count]) begin
                        acc <= acc + ({{W{1'b0}}, mag_b} << count);
                    end
                    if (count == CW'(W-1)) begin
                        state <= FIX;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                FIX: begin
                    resp_product <= neg ? -acc : acc;
                    resp_valid   <= 1'b1;
                    resp_id      <= id;
                    state        <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        rr_ptr     <= (id == IDW'(N_REQ-1)) ? '0 : id + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
